// File: rtl/flag_register_unit.sv
// Architectural condition-code register {Z,N,C,V}: derives flags from ALU results,
// forwards the next value combinationally, and keeps a one-entry save/restore shadow.
module flag_register_unit #(
   parameter int         DATA_WIDTH  = 32,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_carry,
   input  logic                  alu_overflow,
   input  logic                  shifter_carry,
   input  logic                  op_is_logical,
   input  logic                  set_flags,
   input  logic                  flags_wr_en,
   input  logic [3:0]            flags_wr_data,
   input  logic                  save,
   input  logic                  restore,
   input  logic                  stall,
   input  logic                  flush,
   output logic [3:0]            flags_out,
   output logic [3:0]            flags_fwd,
   output logic                  shadow_valid
);

   logic [3:0] r_flags;
   logic [3:0] r_shadow;
   logic       r_shadow_valid;

   logic [3:0] w_new_alu;
   logic [3:0] w_next;
   logic       w_restore_hit;

   always_comb begin
      w_new_alu[3] = (alu_result == '0);
      w_new_alu[2] = alu_result[DATA_WIDTH-1];
      // Logical ops take C from the shifter and leave V untouched.
      w_new_alu[1] = op_is_logical ? shifter_carry : alu_carry;
      w_new_alu[0] = op_is_logical ? r_flags[0] : alu_overflow;
   end

   assign w_restore_hit = restore & r_shadow_valid;

   always_comb begin
      w_next = r_flags;
      if (stall)
         w_next = r_flags;
      else if (w_restore_hit)
         w_next = r_shadow;
      else if (flags_wr_en)
         w_next = flags_wr_data;
      else if (set_flags && !flush)
         w_next = w_new_alu;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags        <= RESET_FLAGS;
         r_shadow       <= 4'b0000;
         r_shadow_valid <= 1'b0;
      end else if (!stall) begin
         r_flags <= w_next;
         // Save captures the pre-update flags; with a concurrent restore this is a swap.
         if (save) begin
            r_shadow       <= r_flags;
            r_shadow_valid <= 1'b1;
         end else if (w_restore_hit) begin
            r_shadow_valid <= 1'b0;
         end
      end
   end

   assign flags_out    = r_flags;
   assign flags_fwd    = reset ? RESET_FLAGS : w_next;
   assign shadow_valid = r_shadow_valid;

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit: directed plan followed by random traffic,
// checked against a flag-level reference model.
module tb_flag_register_unit;

   localparam int DW = 32;

   typedef struct packed {
      logic          rst;
      logic [DW-1:0] res;
      logic          carry;
      logic          ovf;
      logic          scarry;
      logic          logical;
      logic          setf;
      logic          wr_en;
      logic [3:0]    wr_data;
      logic          save;
      logic          restore;
      logic          stall;
      logic          flush;
   } stim_t;

   typedef struct packed {
      logic       chk;
      logic       chk_fwd;
      logic [3:0] fo;
      logic [3:0] fwd;
      logic       sv;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [DW-1:0] alu_result;
   logic          alu_carry, alu_overflow, shifter_carry, op_is_logical;
   logic          set_flags, flags_wr_en, save, restore, stall, flush;
   logic [3:0]    flags_wr_data;
   logic [3:0]    flags_out, flags_fwd;
   logic          shadow_valid;

   flag_register_unit #(.DATA_WIDTH(DW), .RESET_FLAGS(4'b0000)) dut (
      .clk(clk), .reset(reset), .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .shifter_carry(shifter_carry),
      .op_is_logical(op_is_logical), .set_flags(set_flags), .flags_wr_en(flags_wr_en),
      .flags_wr_data(flags_wr_data), .save(save), .restore(restore), .stall(stall),
      .flush(flush), .flags_out(flags_out), .flags_fwd(flags_fwd),
      .shadow_valid(shadow_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference state: flags held as separate named bits.
   logic m_z, m_n, m_c, m_v;
   logic [3:0] m_shadow;
   logic       m_sv;
   logic       m_known;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic cyc(input stim_t s, input logic chk);
      exp_t e;
      logic nz, nn, nc, nv;
      logic [3:0] cur;
      @(posedge clk);
      #1;
      reset = s.rst; alu_result = s.res; alu_carry = s.carry; alu_overflow = s.ovf;
      shifter_carry = s.scarry; op_is_logical = s.logical; set_flags = s.setf;
      flags_wr_en = s.wr_en; flags_wr_data = s.wr_data; save = s.save;
      restore = s.restore; stall = s.stall; flush = s.flush;

      cur = {m_z, m_n, m_c, m_v};
      nz = m_z; nn = m_n; nc = m_c; nv = m_v;
      if (s.rst) begin
         {nz, nn, nc, nv} = 4'b0000;
      end else if (s.stall) begin
         // everything holds
      end else if (s.restore && m_sv) begin
         {nz, nn, nc, nv} = m_shadow;
      end else if (s.wr_en) begin
         {nz, nn, nc, nv} = s.wr_data;
      end else if (s.setf && !s.flush) begin
         nz = (s.res == 0);
         nn = (s.res >= (64'd1 << (DW - 1)));
         nc = s.logical ? s.scarry : s.carry;
         nv = s.logical ? m_v : s.ovf;
      end

      e.chk     = chk && m_known;
      e.chk_fwd = !s.rst;
      e.fo      = cur;
      e.fwd     = {nz, nn, nc, nv};
      e.sv      = m_sv;
      q.push_back(e);

      if (s.rst) begin
         m_shadow = 4'b0000;
         m_sv     = 1'b0;
         m_known  = 1'b1;
      end else if (!s.stall) begin
         if (s.save) begin
            m_shadow = cur;
            m_sv     = 1'b1;
         end else if (s.restore && m_sv) begin
            m_sv = 1'b0;
         end
      end
      {m_z, m_n, m_c, m_v} = {nz, nn, nc, nv};
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         if (e.chk) begin
            checks++;
            if (flags_out !== e.fo) begin
               errors++;
               $display("FAIL flags_out t=%0t got=%b exp=%b", $time, flags_out, e.fo);
            end
            checks++;
            if (shadow_valid !== e.sv) begin
               errors++;
               $display("FAIL shadow_valid t=%0t got=%b exp=%b", $time, shadow_valid, e.sv);
            end
            if (e.chk_fwd) begin
               checks++;
               if (flags_fwd !== e.fwd) begin
                  errors++;
                  $display("FAIL flags_fwd t=%0t got=%b exp=%b", $time, flags_fwd, e.fwd);
               end
            end
         end
      end
   end

   initial begin
      stim_t s;
      m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_shadow = 0; m_sv = 0; m_known = 0;
      reset = 1; alu_result = '0; alu_carry = 0; alu_overflow = 0; shifter_carry = 0;
      op_is_logical = 0; set_flags = 0; flags_wr_en = 0; flags_wr_data = 0;
      save = 0; restore = 0; stall = 0; flush = 0;

      // Reset and idle
      s = idle(); s.rst = 1; cyc(s, 0); cyc(s, 1);
      repeat (3) cyc(idle(), 1);
      s = idle(); s.rst = 1; s.setf = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Arithmetic updates
      s = idle(); s.setf = 1; s.carry = 1; cyc(s, 1);
      s = idle(); s.setf = 1; s.res = 32'h8000_0000; s.ovf = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Logical keeps V
      s = idle(); s.setf = 1; s.logical = 1; s.res = 32'h1; s.scarry = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Stall and flush masking
      s = idle(); s.setf = 1; s.stall = 1; cyc(s, 1); cyc(s, 1);
      s = idle(); s.setf = 1; s.flush = 1; cyc(s, 1);
      s = idle(); s.wr_en = 1; s.wr_data = 4'b1111; s.flush = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Save / restore
      s = idle(); s.wr_en = 1; s.wr_data = 4'b0011; cyc(s, 1);
      s = idle(); s.save = 1; cyc(s, 1);
      s = idle(); s.wr_en = 1; s.wr_data = 4'b1100; cyc(s, 1);
      s = idle(); s.restore = 1; cyc(s, 1);
      s = idle(); s.restore = 1; s.setf = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Swap: flags 1000, shadow 0110 -> flags 0110, shadow 1000
      s = idle(); s.wr_en = 1; s.wr_data = 4'b0110; cyc(s, 1);
      s = idle(); s.save = 1; s.wr_en = 1; s.wr_data = 4'b1000; cyc(s, 1);
      s = idle(); s.save = 1; s.restore = 1; cyc(s, 1);
      s = idle(); s.restore = 1; cyc(s, 1);
      cyc(idle(), 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.rst     = ($urandom_range(0, 49) == 0);
         case ($urandom_range(0, 3))
            0: s.res = '0;
            1: s.res = 32'h8000_0000;
            default: s.res = $urandom;
         endcase
         s.carry   = $urandom_range(0, 1);
         s.ovf     = $urandom_range(0, 1);
         s.scarry  = $urandom_range(0, 1);
         s.logical = $urandom_range(0, 1);
         s.setf    = ($urandom_range(0, 3) != 0);
         s.wr_en   = ($urandom_range(0, 5) == 0);
         s.wr_data = 4'($urandom);
         s.save    = ($urandom_range(0, 5) == 0);
         s.restore = ($urandom_range(0, 5) == 0);
         s.stall   = ($urandom_range(0, 6) == 0);
         s.flush   = ($urandom_range(0, 6) == 0);
         cyc(s, 1);
      end
      cyc(idle(), 1);

      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
